// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - two-source burst-limited arbiter driving a 2:1 mux select
module mux_sel_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_0,
  input  logic       req_1,
  output logic       sel,
  output logic       gnt_0,
  output logic       gnt_1,
  output logic       busy,
  output logic [3:0] burst_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Count value at which the current owner has used its full burst allowance.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t state;
  logic   last;   // most recently granted source; breaks ties in IDLE

  // Arbitration FSM; every output is a register so nothing depends combinationally on req_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      gnt_0     <= 1'b0;
      gnt_1     <= 1'b0;
      busy      <= 1'b0;
      burst_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // Source 0 wins a tie only when source 1 was served last.
          if (req_0 && (!req_1 || last)) begin
            state     <= GRANT0;
            last      <= 1'b0;
            sel       <= 1'b0;
            gnt_0     <= 1'b1;
            gnt_1     <= 1'b0;
            busy      <= 1'b1;
            burst_cnt <= 4'd0;
          end else if (req_1) begin
            state     <= GRANT1;
            last      <= 1'b1;
            sel       <= 1'b1;
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b1;
            busy      <= 1'b1;
            burst_cnt <= 4'd0;
          end else begin
            burst_cnt <= 4'd0;
          end
        end

        GRANT0: begin
          if ((!req_0 || (burst_cnt == BURST_LAST)) && req_1) begin
            // Owner released or exhausted its burst with the other side waiting: hand over directly.
            state     <= GRANT1;
            last      <= 1'b1;
            sel       <= 1'b1;
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b1;
            busy      <= 1'b1;
            burst_cnt <= 4'd0;
          end else if (!req_0) begin
            // Released with nobody waiting; sel keeps its value while idle.
            state     <= IDLE;
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b0;
            busy      <= 1'b0;
            burst_cnt <= 4'd0;
          end else if (burst_cnt == BURST_LAST) begin
            burst_cnt <= 4'd0;
          end else begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end

        GRANT1: begin
          if ((!req_1 || (burst_cnt == BURST_LAST)) && req_0) begin
            state     <= GRANT0;
            last      <= 1'b0;
            sel       <= 1'b0;
            gnt_0     <= 1'b1;
            gnt_1     <= 1'b0;
            busy      <= 1'b1;
            burst_cnt <= 4'd0;
          end else if (!req_1) begin
            state     <= IDLE;
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b0;
            busy      <= 1'b0;
            burst_cnt <= 4'd0;
          end else if (burst_cnt == BURST_LAST) begin
            burst_cnt <= 4'd0;
          end else begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end

        default: begin
          state     <= IDLE;
          gnt_0     <= 1'b0;
          gnt_1     <= 1'b0;
          busy      <= 1'b0;
          burst_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - scoreboard bench for mux_sel_arbiter
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic       req_0;
  logic       req_1;
  logic       sel;
  logic       gnt_0;
  logic       gnt_1;
  logic       busy;
  logic [3:0] burst_cnt;

  int tests_run  = 0;
  int tests_fail = 0;
  int vec_idx    = 0;
  bit stim_done  = 1'b0;

  // Expected {gnt_0, gnt_1, sel, busy, burst_cnt} after the next rising edge.
  logic [7:0] exp_q[$];

  mux_sel_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_0     (req_0),
    .req_1     (req_1),
    .sel       (sel),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .busy      (busy),
    .burst_cnt (burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue the hand-computed response for that edge.
  task automatic step(input logic r, input logic r0, input logic r1,
                      input logic g0, input logic g1, input logic s, input int b);
    @(negedge clk);
    rst   = r;
    req_0 = r0;
    req_1 = r1;
    exp_q.push_back({g0, g1, s, g0 | g1, 4'(b)});
  endtask

  // Monitor: sample shortly after each edge; pop expected values and check invariants.
  always @(posedge clk) begin
    logic [7:0] act;
    logic [7:0] exp;
    #2;
    act = {gnt_0, gnt_1, sel, busy, burst_cnt};
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tests_run++;
      if (act !== exp) begin
        tests_fail++;
        $display("FAIL vec%0d: got g0=%b g1=%b sel=%b busy=%b cnt=%0d, want g0=%b g1=%b sel=%b busy=%b cnt=%0d",
                 vec_idx, act[7], act[6], act[5], act[4], act[3:0],
                 exp[7], exp[6], exp[5], exp[4], exp[3:0]);
      end
      vec_idx++;
    end else if (!stim_done && rst === 1'b0) begin
      tests_run++;
      if (gnt_0 && gnt_1) begin
        tests_fail++;
        $display("FAIL mutex: got g0=%b g1=%b, want not both 1", gnt_0, gnt_1);
      end
      tests_run++;
      if (busy !== (gnt_0 | gnt_1)) begin
        tests_fail++;
        $display("FAIL busy: got %b, want %b", busy, gnt_0 | gnt_1);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req_0 = 1'b1;
    req_1 = 1'b1;

    // Reset with both requests high: outputs stay at reset values.
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);

    // Both requesting: source 0 first (last=1), then alternate every 4 cycles.
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 2);
    step(0, 1, 1, 1, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 1, 1, 0, 1, 1, 2);
    step(0, 1, 1, 0, 1, 1, 3);
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 2);
    step(0, 1, 1, 1, 0, 0, 3);

    // Release: idle, sel holds 0.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Source 1 alone: continuous grant, count wraps at MAX_BURST-1.
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1, 1, 2);
    step(0, 0, 1, 0, 1, 1, 3);
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1, 1, 2);
    step(0, 0, 1, 0, 1, 1, 3);
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 1);

    // Source 1 releases with source 0 quiet: idle, sel holds 1.
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // GRANT0 at count 1, req_0 falls as req_1 rises: direct switch.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0);

    // Reset mid-burst in GRANT1 at count 2 with both high, then source 0 wins.
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 1, 1, 0, 1, 1, 2);
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1);

    // Tie from idle with last=0 goes to source 1.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Wait for the queue to drain before random traffic.
    repeat (3) @(negedge clk);

    // Random traffic: invariant checks only.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 199) == 0);
      req_0 = $urandom_range(0, 1) == 1;
      req_1 = $urandom_range(0, 1) == 1;
    end

    @(negedge clk);
    stim_done = 1'b1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
